// File: rtl/writeback_regfile.sv
// Write-back stage: selects the MEM/WB result, commits it to a 32-entry register file
// and serves the two decode read ports with same-cycle write-through bypass.
module writeback_regfile #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned RETIRE_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    regWrite,
  input  logic                    memToReg,
  input  logic [DATA_WIDTH-1:0]   readData,
  input  logic [DATA_WIDTH-1:0]   aluResult,
  input  logic [ADDR_WIDTH-1:0]   writeReg,
  input  logic [ADDR_WIDTH-1:0]   readReg1,
  input  logic [ADDR_WIDTH-1:0]   readReg2,
  output logic [DATA_WIDTH-1:0]   readData1,
  output logic [DATA_WIDTH-1:0]   readData2,
  output logic [DATA_WIDTH-1:0]   writeData,
  output logic [ADDR_WIDTH-1:0]   lastWriteReg,
  output logic [RETIRE_WIDTH-1:0] retireCount
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]   r_regs [DEPTH];
  logic [ADDR_WIDTH-1:0]   r_last_write_reg;
  logic [RETIRE_WIDTH-1:0] r_retire_count;

  logic                    w_commit;
  logic [DATA_WIDTH-1:0]   w_write_data;
  logic [DATA_WIDTH-1:0]   w_read_data1;
  logic [DATA_WIDTH-1:0]   w_read_data2;

  // Index 0 is architecturally zero, so a write to it is not a commit at all.
  assign w_commit     = regWrite && (writeReg != '0);
  assign w_write_data = memToReg ? readData : aluResult;

  // Architectural state; r_regs[0] is only ever loaded with zero by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_last_write_reg <= '0;
      r_retire_count   <= '0;
    end else if (w_commit) begin
      r_regs[writeReg] <= w_write_data;
      r_last_write_reg <= writeReg;
      r_retire_count   <= r_retire_count + RETIRE_WIDTH'(1);
    end
  end

  // Decode reads: zero for index 0, otherwise bypass the in-flight commit.
  always_comb begin
    w_read_data1 = '0;
    w_read_data2 = '0;
    if (readReg1 != '0) begin
      w_read_data1 = (w_commit && (readReg1 == writeReg)) ? w_write_data : r_regs[readReg1];
    end
    if (readReg2 != '0) begin
      w_read_data2 = (w_commit && (readReg2 == writeReg)) ? w_write_data : r_regs[readReg2];
    end
  end

  assign readData1    = w_read_data1;
  assign readData2    = w_read_data2;
  assign writeData    = w_write_data;
  assign lastWriteReg = r_last_write_reg;
  assign retireCount  = r_retire_count;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile; a second narrow-counter instance shares the
// stimulus so the retire counter wrap can be reached in a handful of commits.
module tb_writeback_regfile;

  logic        clk;
  logic        reset;
  logic        regWrite;
  logic        memToReg;
  logic [31:0] readData;
  logic [31:0] aluResult;
  logic [4:0]  writeReg;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] writeData;
  logic [4:0]  lastWriteReg;
  logic [31:0] retireCount;

  logic [31:0] w_rd1_n;
  logic [31:0] w_rd2_n;
  logic [31:0] w_wd_n;
  logic [4:0]  w_last_n;
  logic [2:0]  w_retire_n;

  int n_cmp = 0;
  int n_err = 0;

  writeback_regfile dut (
    .clk          (clk),
    .reset        (reset),
    .regWrite     (regWrite),
    .memToReg     (memToReg),
    .readData     (readData),
    .aluResult    (aluResult),
    .writeReg     (writeReg),
    .readReg1     (readReg1),
    .readReg2     (readReg2),
    .readData1    (readData1),
    .readData2    (readData2),
    .writeData    (writeData),
    .lastWriteReg (lastWriteReg),
    .retireCount  (retireCount)
  );

  writeback_regfile #(.RETIRE_WIDTH(3)) u_wrap (
    .clk          (clk),
    .reset        (reset),
    .regWrite     (regWrite),
    .memToReg     (memToReg),
    .readData     (readData),
    .aluResult    (aluResult),
    .writeReg     (writeReg),
    .readReg1     (readReg1),
    .readReg2     (readReg2),
    .readData1    (w_rd1_n),
    .readData2    (w_rd2_n),
    .writeData    (w_wd_n),
    .lastWriteReg (w_last_n),
    .retireCount  (w_retire_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a committing write and let one rising edge take it.
  task automatic do_write(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clk);
    regWrite  = 1'b1;
    memToReg  = 1'b0;
    aluResult = val;
    writeReg  = idx;
    @(posedge clk);
    #1;
    regWrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; regWrite = 1'b0; memToReg = 1'b0;
    readData = '0; aluResult = '0; writeReg = '0; readReg1 = 5'd5; readReg2 = '0;
    #1;
    check("rst_rd1", readData1, 32'h0);
    check("rst_last", 32'(lastWriteReg), 32'h0);
    check("rst_retire", retireCount, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset between edges clears state immediately
    do_write(5'd5, 32'h0000_1234);
    readReg1 = 5'd5;
    #1;
    check("w5_rd1", readData1, 32'h0000_1234);
    check("w5_retire", retireCount, 32'd1);
    check("w5_last", 32'(lastWriteReg), 32'd5);
    #1 reset = 1'b1;
    #1;
    check("async_rst_rd1", readData1, 32'h0);
    check("async_rst_last", 32'(lastWriteReg), 32'h0);
    check("async_rst_retire", retireCount, 32'h0);
    #1 reset = 1'b0;

    // Write-back mux and commit
    @(negedge clk);
    regWrite = 1'b1; memToReg = 1'b0;
    aluResult = 32'hA5A5_A5A5; readData = 32'h5A5A_5A5A; writeReg = 5'd3;
    #1 check("mux_alu", writeData, 32'hA5A5_A5A5);
    @(posedge clk);
    #1;
    memToReg = 1'b1; writeReg = 5'd4;
    #1 check("mux_mem", writeData, 32'h5A5A_5A5A);
    @(posedge clk);
    #1;
    regWrite = 1'b0; readReg1 = 5'd3; readReg2 = 5'd4;
    #1;
    check("reg3", readData1, 32'hA5A5_A5A5);
    check("reg4", readData2, 32'h5A5A_5A5A);
    check("mux_retire", retireCount, 32'd2);
    check("mux_last", 32'(lastWriteReg), 32'd4);

    // Register 0 stays zero, no retire
    @(negedge clk);
    regWrite = 1'b1; memToReg = 1'b0; aluResult = 32'hFFFF_FFFF; writeReg = 5'd0;
    readReg1 = 5'd0; readReg2 = 5'd0;
    #1;
    check("r0_pre_rd1", readData1, 32'h0);
    check("r0_pre_rd2", readData2, 32'h0);
    @(posedge clk);
    #1;
    check("r0_post_rd1", readData1, 32'h0);
    check("r0_retire", retireCount, 32'd2);
    check("r0_last", 32'(lastWriteReg), 32'd4);
    regWrite = 1'b0;

    // Bypass on both ports
    do_write(5'd7, 32'h11);
    @(negedge clk);
    regWrite = 1'b1; memToReg = 1'b0; aluResult = 32'h22; writeReg = 5'd7;
    readReg1 = 5'd7; readReg2 = 5'd7;
    #1;
    check("byp_rd1", readData1, 32'h22);
    check("byp_rd2", readData2, 32'h22);
    regWrite = 1'b0;
    #1;
    check("nobyp_rd1", readData1, 32'h11);
    check("nobyp_rd2", readData2, 32'h11);
    regWrite = 1'b1;
    @(posedge clk);
    #1;
    regWrite = 1'b0;
    #1;
    check("byp_post_rd1", readData1, 32'h22);
    check("byp_post_rd2", readData2, 32'h22);
    check("byp_retire", retireCount, 32'd4);
    check("byp_last", 32'(lastWriteReg), 32'd7);

    // No-write cycles leave everything untouched
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      regWrite = 1'b0; memToReg = i[0];
      writeReg = 5'(i + 1); aluResult = 32'(i) * 32'h0101_0101; readData = ~aluResult;
    end
    @(posedge clk);
    #1;
    readReg1 = 5'd3; readReg2 = 5'd4;
    #1;
    check("nw_reg3", readData1, 32'hA5A5_A5A5);
    check("nw_reg4", readData2, 32'h5A5A_5A5A);
    readReg1 = 5'd7; readReg2 = 5'd5;
    #1;
    check("nw_reg7", readData1, 32'h22);
    check("nw_reg5", readData2, 32'h0);
    check("nw_retire", retireCount, 32'd4);
    check("nw_last", 32'(lastWriteReg), 32'd7);

    // Narrow counter wraps 7 -> 0 on the eighth commit
    do_write(5'd10, 32'h100);
    do_write(5'd11, 32'h101);
    do_write(5'd12, 32'h102);
    check("wrap_pre", 32'(w_retire_n), 32'd7);
    do_write(5'd13, 32'h103);
    check("wrap_zero", 32'(w_retire_n), 32'd0);
    check("wrap_wide", retireCount, 32'd8);
    check("wrap_last", 32'(lastWriteReg), 32'd13);

    // Reset coincident with a commit edge wins
    @(negedge clk);
    regWrite = 1'b1; memToReg = 1'b0; aluResult = 32'h33; writeReg = 5'd9;
    readReg1 = 5'd9; readReg2 = 5'd13;
    @(posedge clk);
    reset = 1'b1;
    #1;
    regWrite = 1'b0;
    #1;
    check("race_reg9", readData1, 32'h0);
    check("race_reg13", readData2, 32'h0);
    check("race_retire", retireCount, 32'h0);
    check("race_wrap_retire", 32'(w_retire_n), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    do_write(5'd9, 32'h33);
    check("post_rst_reg9", readData1, 32'h33);
    check("post_rst_retire", retireCount, 32'd1);
    check("post_rst_last", 32'(lastWriteReg), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Consumer end of the MEM/WB pipeline register.
- Takes the latched memory read data, ALU result, destination register index and the WB control bits (regWrite, memToReg).
- Selects the write-back value and commits it to a 32-entry general-purpose register file.
- Serves the two decode-stage read ports, with write-through bypass, so ID sees the value being written back in the same cycle.

Parameters:
DATA_WIDTH, 32, width of each register and of all data ports
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
RETIRE_WIDTH, 32, width of the write-back retire counter

Ports:
clk  input  1  pipeline clock, rising-edge active
reset  input  1  asynchronous, active-high reset
regWrite  input  1  WB control: commit write this cycle
memToReg  input  1  WB control: 1 selects readData, 0 selects aluResult
readData  input  DATA_WIDTH  memory load data from MEM/WB
aluResult  input  DATA_WIDTH  ALU result from MEM/WB
writeReg  input  ADDR_WIDTH  destination register index from MEM/WB
readReg1  input  ADDR_WIDTH  decode read port 1 index
readReg2  input  ADDR_WIDTH  decode read port 2 index
readData1  output  DATA_WIDTH  port 1 data (combinational)
readData2  output  DATA_WIDTH  port 2 data (combinational)
writeData  output  DATA_WIDTH  selected write-back value, for forwarding (combinational)
lastWriteReg  output  ADDR_WIDTH  index of the most recent committed write (registered)
retireCount  output  RETIRE_WIDTH  number of committed writes (registered)

Behaviour:
- Reset:
  - Asynchronous on reset rising, held while reset=1.
  - Clears all registers, lastWriteReg and retireCount to 0.
  - writeData and readData1/2 then reflect the cleared state and current inputs.
- Write-back mux: writeData = memToReg ? readData : aluResult. Pure combinational, no latency.
- Commit:
  - Condition: posedge clk with reset=0, regWrite=1 and writeReg != 0.
  - Effect: reg[writeReg] <= writeData; lastWriteReg <= writeReg; retireCount <= retireCount + 1.
- Register 0:
  - Hardwired to 0. Writes to index 0 are discarded.
  - lastWriteReg and retireCount do not change on a write to index 0.
  - Reads of index 0 return 0, including under bypass.
- regWrite=0: no state changes; memToReg, readData and aluResult are don't-care for state.
- Reads: readDataN = reg[readRegN], combinational.
- Bypass:
  - Applies when regWrite=1, writeReg != 0 and readRegN == writeReg in the same cycle.
  - Then readDataN = writeData, so a decode read in the write-back cycle returns the new value.
  - Both ports may bypass simultaneously.
  - Both ports may read the same index.
- Counter: retireCount wraps modulo 2**RETIRE_WIDTH (0xFFFFFFFF + 1 -> 0). No saturation, no flag.
- Reset mid-operation:
  - Reset asserted coincident with a commit edge wins; no write occurs.
  - The first commit is possible on the first rising edge after reset deasserts.
- Inputs are sampled only at the rising edge. No X is generated from a defined input.
- Total latency: one cycle from MEM/WB outputs to architectural state; zero cycles to readDataN via bypass.

Test Plan:
- Reset sequence:
  - Stimulus: write reg 5 = 0x1234, then pulse reset asynchronously between edges.
  - Required: readData1 (readReg1=5) = 0, lastWriteReg = 0, retireCount = 0 immediately, before the next edge.
- Mux and commit:
  - Stimulus: regWrite=1, memToReg=0, aluResult=0xA5A5A5A5, readData=0x5A5A5A5A, writeReg=3; then memToReg=1, writeReg=4.
  - Required: reg3 = 0xA5A5A5A5, reg4 = 0x5A5A5A5A, retireCount = 2, lastWriteReg = 4.
- Register 0:
  - Stimulus: regWrite=1, writeReg=0, aluResult=0xFFFFFFFF, readReg1=0.
  - Required: readData1 = 0 before and after the edge; retireCount and lastWriteReg unchanged.
- Bypass:
  - Stimulus: reg7 = 0x11; same cycle regWrite=1, writeReg=7, aluResult=0x22, readReg1=readReg2=7.
  - Required: both reads = 0x22 before the edge and after it. With regWrite=0 the reads show 0x11.
- No-write:
  - Stimulus: regWrite=0 with varying writeReg, aluResult and readData for 10 cycles.
  - Required: all registers, lastWriteReg and retireCount unchanged.
- Wrap and reset race:
  - Stimulus: force retireCount = 0xFFFFFFFF, commit one write → 0. Then assert reset on the same edge as a commit to reg 9 = 0x33.
  - Required: reg9 = 0, retireCount = 0.
